// File: rtl/credit_delay_queue_pkg.sv
// Shared DART constants for the simulated-channel credit blocks.
// Defaults for timestamp and latency widths, plus a constant-foldable clog2.
package credit_delay_queue_pkg;

    localparam int DART_TS_WIDTH  = 6;
    localparam int DART_LAT_WIDTH = 4;
    localparam int DART_DEPTH     = 8;

    // Usable in parameter and port-width expressions.
    function automatic int dart_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/credit_ts_fifo.sv
// Synchronous DEPTH x WIDTH FIFO holding credit release timestamps.
// A push while full is accepted only when a pop happens in the same cycle.
module credit_ts_fifo
    import credit_delay_queue_pkg::*;
#(
    parameter int DEPTH = DART_DEPTH,
    parameter int WIDTH = DART_TS_WIDTH,
    localparam int AW   = dart_clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_delay_queue.sv
// Credit return wire model: time-stamps arriving credits and releases each one
// to the upstream credit counter once its configured latency in sim ticks has elapsed.
module credit_delay_queue
    import credit_delay_queue_pkg::*;
#(
    parameter int DEPTH     = DART_DEPTH,
    parameter int LAT_WIDTH = DART_LAT_WIDTH,
    parameter int TS_WIDTH  = DART_TS_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      sim_time_tick,
    input  logic [LAT_WIDTH-1:0]      config_in,
    input  logic                      config_in_valid,
    output logic [LAT_WIDTH-1:0]      config_out,
    output logic                      config_out_valid,
    input  logic                      credit_in_valid,
    output logic                      credit_out_valid,
    input  logic                      credit_out_ack,
    output logic [dart_clog2(DEPTH):0] occupancy,
    output logic                      overflow
);

    logic [TS_WIDTH-1:0]  r_now;
    logic [LAT_WIDTH-1:0] r_latency;
    logic                 r_overflow;

    logic                 w_tick;
    logic                 w_push_req;
    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_due;
    logic [TS_WIDTH-1:0]  w_head_ts;
    logic [TS_WIDTH-1:0]  w_push_ts;
    logic [TS_WIDTH-1:0]  w_age;

    assign w_tick     = enable & sim_time_tick;
    assign w_push_req = enable & credit_in_valid;
    assign w_push_ts  = r_now + TS_WIDTH'(r_latency);

    // Latency stays below half the timestamp range, so the sign of the
    // modular age tells "not yet due" apart from "due", across wrap-around.
    assign w_age = r_now - w_head_ts;
    assign w_due = ~w_age[TS_WIDTH-1];

    assign credit_out_valid = enable & ~w_empty & w_due;
    assign w_pop            = credit_out_valid & credit_out_ack;
    assign w_push_ok        = w_push_req & (~w_full | w_pop);

    assign config_out       = r_latency;
    assign config_out_valid = config_in_valid;
    assign overflow         = r_overflow;

    credit_ts_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_WIDTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push_ok),
        .pop   (w_pop),
        .din   (w_push_ts),
        .dout  (w_head_ts),
        .full  (w_full),
        .empty (w_empty),
        .count (occupancy)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_now      <= '0;
            r_latency  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_tick) begin
                r_now <= r_now + 1'b1;
            end
            if (config_in_valid) begin
                r_latency <= config_in;
            end
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_credit_delay_queue.sv
// Bench for credit_delay_queue: directed scenarios then random traffic, all
// checked each cycle against a model that counts absolute sim ticks.
module tb_credit_delay_queue;

    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          sim_time_tick;
    logic [LW-1:0] config_in;
    logic          config_in_valid;
    logic [LW-1:0] config_out;
    logic          config_out_valid;
    logic          credit_in_valid;
    logic          credit_out_valid;
    logic          credit_out_ack;
    logic [3:0]    occupancy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Model: release times as absolute tick numbers, no modular arithmetic.
    int m_ticks;
    int m_lat;
    bit m_ovf;
    int m_q[$];

    credit_delay_queue #(.DEPTH(DEPTH), .LAT_WIDTH(LW), .TS_WIDTH(6)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .sim_time_tick    (sim_time_tick),
        .config_in        (config_in),
        .config_in_valid  (config_in_valid),
        .config_out       (config_out),
        .config_out_valid (config_out_valid),
        .credit_in_valid  (credit_in_valid),
        .credit_out_valid (credit_out_valid),
        .credit_out_ack   (credit_out_ack),
        .occupancy        (occupancy),
        .overflow         (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, compare outputs against the model, then clock
    // the model with the same inputs.
    task automatic step(input bit en, input bit tick, input bit civ, input bit ack,
                        input bit cfg_v = 1'b0, input int cfg_d = 0, input bit rst_n = 1'b1);
        bit exp_valid;
        bit pop;
        bit push_req;
        bit accept;
        enable          = en;
        sim_time_tick   = tick;
        credit_in_valid = civ;
        credit_out_ack  = ack;
        config_in_valid = cfg_v;
        config_in       = LW'(cfg_d);
        reset           = rst_n;
        #1;
        exp_valid = en && (m_q.size() > 0) && (m_ticks >= m_q[0]);
        check("credit_out_valid", 32'(credit_out_valid), 32'(exp_valid));
        check("occupancy", 32'(occupancy), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("config_out", 32'(config_out), 32'(m_lat));
        check("config_out_valid", 32'(config_out_valid), 32'(cfg_v));
        if (!rst_n) begin
            m_q.delete();
            m_ticks = 0;
            m_lat   = 0;
            m_ovf   = 1'b0;
        end else begin
            pop      = exp_valid && ack;
            push_req = en && civ;
            accept   = push_req && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back(m_ticks + m_lat);
            if (push_req && !accept) m_ovf = 1'b1;
            if (en && tick) m_ticks++;
            if (cfg_v) m_lat = cfg_d;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        enable = 0; sim_time_tick = 0; credit_in_valid = 0; credit_out_ack = 0;
        config_in_valid = 0; config_in = '0; reset = 0;
        m_ticks = 0; m_lat = 0; m_ovf = 0;
        @(posedge clock);
        #1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_occupancy", 32'(occupancy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_config_out", 32'(config_out), 32'd0);

        // L=0: visible next cycle, then acked away.
        step(1, 0, 1, 0);
        check("l0_valid_next_cycle", 32'(credit_out_valid), 32'd1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);

        // L=3 with ticks every 4 cycles; hold ack low after release.
        step(1, 0, 0, 0, 1, 3);
        step(1, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, (i % 4) == 3, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);

        // L=15: nine back-to-back pushes overflow; once head is due, push+pop at full.
        step(1, 0, 0, 0, 1, 15);
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0);
        step(1, 0, 1, 1);
        check("full_push_pop_occupancy", 32'(occupancy), 32'd8);
        for (int i = 0; i < 24; i++) step(1, 1, 0, 1);

        // r_now wrap: advance to 62, L=5.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 62; i++) step(1, 1, 0, 0);
        step(1, 0, 0, 0, 1, 5);
        step(1, 0, 1, 0);
        for (int i = 0; i < 14; i++) step(1, i % 2, 0, 1);

        // Reconfigure 2 -> 7 with one credit queued.
        step(1, 0, 0, 0, 1, 2);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 7);
        check("config_out_seven", 32'(config_out), 32'd7);
        step(1, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, i % 2, 0, 1);

        // enable=0 freezes everything.
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1);

        // Reset mid-stream.
        step(1, 0, 0, 0, 1, 9);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        check("midreset_occupancy", 32'(occupancy), 32'd0);
        check("midreset_config_out", 32'(config_out), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 299) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
